regfile_sb: RTL
===============

# regfile_sb

Parametrised general-purpose register file for the pipelined MIPS datapath: two combinational read ports, one synchronous write port, a per-register busy scoreboard for hazard detection in decode, and a post-reset initialisation sweep. It sits in the ID stage. The read ports feed the ID/EX operand latches, the write port is driven from WB, and the issue port is driven by decode when an instruction with a destination register leaves ID.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W entries

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_addr_2  in  ADDR_W  read port 2 address
- rd_data_1  out  DATA_W  read port 1 data (combinational)
- rd_data_2  out  DATA_W  read port 2 data (combinational)
- rd_busy_1  out  1  register at rd_addr_1 has a pending write
- rd_busy_2  out  1  register at rd_addr_2 has a pending write
- wr_en  in  1  write strobe from WB
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- issue_en  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination of the issued instruction
- init_done  out  1  initialisation sweep complete; block accepts traffic

## Operation
- Reset is asynchronous. rst_n low forces the following:
  - FSM = INIT, sweep index = 0
  - all busy bits = 0, init_done = 0
- The storage array itself is not reset.
- FSM INIT:
  - Each posedge writes regs[idx] = idx (zero-extended or truncated to DATA_W), then idx increments.
  - At the posedge that writes idx = DEPTH-1, the FSM moves to RUN and init_done is set to 1.
- FSM RUN: terminal state; only reset leaves it.
- While in INIT:
  - wr_en and issue_en are ignored.
  - rd_data_1/2 = 0 and rd_busy_1/2 = 1.
- Register 0 is hardwired to zero in RUN:
  - Reads of address 0 return 0 and busy 0.
  - A write or issue to address 0 has no effect.
- Write (RUN): when wr_en and wr_addr != 0, regs[wr_addr] = wr_data at the posedge, and busy[wr_addr] is cleared.
- Issue (RUN): when issue_en and issue_addr != 0, busy[issue_addr] is set at the posedge.
- Simultaneous issue and write to the same address: the set wins and busy stays 1, since a new producer is in flight.
- Both read ports may address the same register. Each port resolves independently.
- Reset asserted mid-operation aborts everything. The block returns to INIT and the sweep restarts at entry 0.

## Timing
- After rst_n rises, init_done rises immediately after the DEPTH-th posedge (8 cycles at default).
- Write latency: 1 cycle. Data is visible on the read ports after the posedge that samples wr_en, unless bypass is enabled.
- Busy update latency: 1 cycle after the issue or write posedge.
- Read ports are purely combinational from the addresses and state; there are no read handshakes.
- Reset values:
  - rd_data_1/2 = 0, rd_busy_1/2 = 1 (INIT forcing)
  - init_done = 0

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined (RUN state, per read port): if wr_en and wr_addr == rd_addr and wr_addr != 0:
  - rd_data = wr_data in the same cycle (write-through forwarding)
  - rd_busy = 0, unless issue_en to the same address occurs in the same cycle, in which case rd_busy = 1
- Undefined:
  - rd_data returns the stored value, so the new value appears one cycle later.
  - rd_busy reflects the stored busy bit only.
- Both variants must pass the full test plan, with expectations keyed to the macro.

## Test plan
- Reset then release, no traffic:
  - During 8 cycles: init_done = 0, rd_busy = 1, rd_data = 0.
  - Afterwards: init_done = 1; reading addresses 0..7 returns 0x0000..0x0007.
- RUN, wr_en = 1, wr_addr = 5, wr_data = 0xBEEF, rd_addr_1 = 5 in the same cycle:
  - With REGFILE_BYPASS_EN: rd_data_1 = 0xBEEF immediately.
  - Without: rd_data_1 = 0x0005 that cycle and 0xBEEF after the edge.
- Write to address 0 with 0xFFFF, plus issue to address 0:
  - rd_data = 0 and rd_busy = 0 on both ports afterwards.
- Scoreboard sequence:
  - Issue to r3 → rd_busy(r3) = 1 next cycle.
  - Write r3 = 0x1234 with a simultaneous issue to r3 → busy stays 1.
  - Write r3 alone → busy = 0.
- Mid-sweep and mid-traffic reset:
  - Assert rst_n = 0 at INIT idx = 4 → init_done = 0 and busy bits cleared immediately.
  - On release, the sweep restarts at 0 and completes 8 cycles later.
  - Repeat from RUN with r2 busy → r2 is not busy after re-init.
- Both read ports on r6 during a write to r6 (0x00AA):
  - Both ports return identical data and busy, per the macro setting.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and a post-reset sweep that loads regs[i] = i.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic [DATA_W-1:0] rd_data_1,
   output logic [DATA_W-1:0] rd_data_2,
   output logic              rd_busy_1,
   output logic              rd_busy_2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              init_done
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;
   logic              init_done_reg, init_done_next;
   logic [DEPTH-1:0]  busy_reg, busy_next;
   logic [DATA_W-1:0] regs [DEPTH];

   logic run;
   logic wr_ok;
   logic issue_ok;

   // Register 0 is never written or marked busy once running.
   assign run      = (state_reg == ST_RUN);
   assign wr_ok    = run && wr_en && (wr_addr != '0);
   assign issue_ok = run && issue_en && (issue_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_INIT;
         idx_reg       <= '0;
         init_done_reg <= 1'b0;
         busy_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         init_done_reg <= init_done_next;
         busy_reg      <= busy_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      init_done_next = init_done_reg;
      case (state_reg)
         ST_INIT: begin
            idx_next = idx_reg + 1'b1;
            if (idx_reg == ADDR_W'(DEPTH - 1)) begin
               state_next     = ST_RUN;
               init_done_next = 1'b1;
            end
         end
         ST_RUN: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // A same-cycle issue beats the write clear: a newer producer is in flight.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_busy
         assign busy_next[gi] =
            (issue_ok && (issue_addr == ADDR_W'(gi))) ? 1'b1 :
            (wr_ok    && (wr_addr    == ADDR_W'(gi))) ? 1'b0 :
            busy_reg[gi];
      end
   endgenerate

   // Storage has no reset; the sweep provides its initial contents.
   always_ff @(posedge clk) begin
      if (state_reg == ST_INIT) begin
         regs[idx_reg] <= DATA_W'(idx_reg);
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data_c;
         logic              busy_c;

         assign addr = (gi == 0) ? rd_addr_1 : rd_addr_2;

         always_comb begin
            data_c = '0;
            busy_c = 1'b1;
            if (run) begin
               if (addr == '0) begin
                  data_c = '0;
                  busy_c = 1'b0;
               end
`ifdef REGFILE_BYPASS_EN
               else if (wr_ok && (wr_addr == addr)) begin
                  data_c = wr_data;
                  busy_c = issue_ok && (issue_addr == addr);
               end
`endif
               else begin
                  data_c = regs[addr];
                  busy_c = busy_reg[addr];
               end
            end
         end

         if (gi == 0) begin : g_out1
            assign rd_data_1 = data_c;
            assign rd_busy_1 = busy_c;
         end else begin : g_out2
            assign rd_data_2 = data_c;
            assign rd_busy_2 = busy_c;
         end
      end
   endgenerate

   assign init_done = init_done_reg;

endmodule
